// File: rtl/posit_defines.sv
// Shared constants and serialized word layouts for the es=2 posit datapath.
package posit_defines;

    localparam int NBITS = 32;
    localparam int ES    = 2;

    // Largest representable |scale|: regime span (NBITS-2) weighted by 2^ES.
    localparam int MAX_SCALE = (1 << ES) * (NBITS - 2);

    localparam int POSIT_SERIALIZED_WIDTH_ES2         = 38;
    localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES2 = 68;

    // Product fraction width (two 28-bit mantissas multiplied).
    localparam int MBITS = 56;

    // Unpacked operand: hidden bit is implied, not stored.
    typedef struct packed {
        logic              sgn;
        logic signed [7:0] scale;
        logic [26:0]       fraction;
        logic              inf;
        logic              zero;
    } value;

    // Serialized product handed to the normalize/round stage.
    typedef struct packed {
        logic              sgn;
        logic signed [8:0] scale;
        logic [MBITS-1:0]  fraction;
        logic              inf;
        logic              zero;
    } value_product;

endpackage

// File: rtl/posit_mult_norm_clamp.sv
// Final-stage product normalization, scale clamp and special-value override.
module posit_mult_norm_clamp
    import posit_defines::*;
(
    input  logic                    sgn,
    input  logic signed [8:0]       ssum,
    input  logic [MBITS-1:0]        prod,
    input  logic                    inf,
    input  logic                    zero,
    output value_product            result,
    output logic                    truncated
);

    localparam logic signed [9:0] SCALE_HI = 10'(MAX_SCALE);
    localparam logic signed [9:0] SCALE_LO = -SCALE_HI;

    logic signed [9:0] scale_w;
    logic [MBITS-1:0]  frac_w;

    // Mantissa product lies in [1,4); shift out the leading one and clamp the scale.
    always_comb begin
        result    = '0;
        truncated = 1'b0;
        scale_w   = '0;
        frac_w    = '0;
        if (inf) begin
            result.inf = 1'b1;
        end else if (zero) begin
            result.zero = 1'b1;
        end else begin
            if (prod[MBITS-1]) begin
                scale_w = {ssum[8], ssum} + 10'sd1;
                frac_w  = {prod[MBITS-2:0], 1'b0};
            end else begin
                scale_w = {ssum[8], ssum};
                frac_w  = {prod[MBITS-3:0], 2'b00};
            end
            result.sgn = sgn;
            if (scale_w > SCALE_HI) begin
                result.scale    = SCALE_HI[8:0];
                result.fraction = '0;
            end else if (scale_w < SCALE_LO) begin
                result.scale    = SCALE_LO[8:0];
                result.fraction = '0;
                truncated       = 1'b1;
            end else begin
                result.scale    = scale_w[8:0];
                result.fraction = frac_w;
            end
        end
    end

endmodule

// File: rtl/posit_mult_es2.sv
// Three-stage pipelined posit (32,2) multiplier with valid/ready on both sides.
module posit_mult_es2
    import posit_defines::*;
(
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]         in1,
    input  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]         in2,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES2-1:0] result,
    output logic                                          truncated
);

    value a;
    value b;
    logic [27:0] mant_a;
    logic [27:0] mant_b;
    logic [41:0] pp_hi_c;
    logic [41:0] pp_lo_c;
    logic        inf_c;
    logic        zero_c;

    logic v1, v2, v3;
    logic load1, load2, load3;
    logic ready_en;

    logic              s1_sgn, s1_inf, s1_zero;
    logic signed [8:0] s1_ssum;
    logic [41:0]       s1_pp_hi, s1_pp_lo;

    logic              s2_sgn, s2_inf, s2_zero;
    logic signed [8:0] s2_ssum;
    logic [MBITS-1:0]  s2_prod;

    value_product nc_result;
    logic         nc_truncated;
    value_product result_q;
    logic         trunc_q;

    assign a = value'(in1);
    assign b = value'(in2);

    // Split B so each multiplier is 28x14 rather than one 28x28.
    assign mant_a  = {1'b1, a.fraction};
    assign mant_b  = {1'b1, b.fraction};
    assign pp_hi_c = 42'(mant_a) * 42'(mant_b[27:14]);
    assign pp_lo_c = 42'(mant_a) * 42'(mant_b[13:0]);

    // Infinity dominates zero, so inf*0 reports inf.
    assign inf_c  = a.inf | b.inf;
    assign zero_c = ~inf_c & (a.zero | b.zero);

    // A stage loads when empty or when its contents move on this cycle.
    assign load3    = ~v3 | out_ready;
    assign load2    = ~v2 | load3;
    assign load1    = ~v1 | load2;
    assign in_ready = ready_en & load1;

    assign out_valid = v3;
    assign result    = result_q;
    assign truncated = trunc_q;

    // Hold off input acceptance until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Stage 1: sign, scale sum, special flags and partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_ssum  <= '0;
            s1_pp_hi <= '0;
            s1_pp_lo <= '0;
        end else if (load1) begin
            v1 <= in_valid & in_ready;
            if (in_valid & in_ready) begin
                s1_sgn   <= a.sgn ^ b.sgn;
                s1_inf   <= inf_c;
                s1_zero  <= zero_c;
                s1_ssum  <= {a.scale[7], a.scale} + {b.scale[7], b.scale};
                s1_pp_hi <= pp_hi_c;
                s1_pp_lo <= pp_lo_c;
            end
        end
    end

    // Stage 2: recombine partial products into the full 56-bit mantissa product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_sgn  <= 1'b0;
            s2_inf  <= 1'b0;
            s2_zero <= 1'b0;
            s2_ssum <= '0;
            s2_prod <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                s2_sgn  <= s1_sgn;
                s2_inf  <= s1_inf;
                s2_zero <= s1_zero;
                s2_ssum <= s1_ssum;
                s2_prod <= {s1_pp_hi, 14'b0} + {14'b0, s1_pp_lo};
            end
        end
    end

    posit_mult_norm_clamp u_norm_clamp (
        .sgn       (s2_sgn),
        .ssum      (s2_ssum),
        .prod      (s2_prod),
        .inf       (s2_inf),
        .zero      (s2_zero),
        .result    (nc_result),
        .truncated (nc_truncated)
    );

    // Stage 3: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            result_q <= '0;
            trunc_q  <= 1'b0;
        end else if (load3) begin
            v3 <= v2;
            if (v2) begin
                result_q <= nc_result;
                trunc_q  <= nc_truncated;
            end
        end
    end

endmodule

// File: tb/tb_posit_mult_es2.sv
// Scoreboard bench for posit_mult_es2: directed products, back-pressure and reset.
module tb_posit_mult_es2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] in1;
    logic [37:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [67:0] result;
    logic        truncated;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    bit check_ready = 1'b0;
    bit prev_stall  = 1'b0;
    logic [68:0] prev_word = '0;
    logic [68:0] exp_q[$];

    always #5 clk = ~clk;

    posit_mult_es2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .truncated (truncated)
    );

    // Single comparison point: counts and reports.
    task automatic check_output(input string tag, input logic [68:0] observed, input logic [68:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference product {truncated, result} from one full-width multiply.
    function automatic logic [68:0] model_product(input logic [37:0] a, input logic [37:0] b);
        logic        sgn;
        int          sc;
        logic [55:0] ma, mb, p, frac;
        logic        tr;
        if (a[1] | b[1]) return {1'b0, 68'h2};
        if (a[0] | b[0]) return {1'b0, 68'h1};
        sgn = a[37] ^ b[37];
        sc  = $signed(a[36:29]) + $signed(b[36:29]);
        ma  = {28'b0, 1'b1, a[28:2]};
        mb  = {28'b0, 1'b1, b[28:2]};
        p   = ma * mb;
        if (p[55]) begin
            sc++;
            frac = p << 1;
        end else begin
            frac = p << 2;
        end
        tr = 1'b0;
        if (sc > 120) begin
            sc = 120; frac = '0;
        end else if (sc < -120) begin
            sc = -120; frac = '0; tr = 1'b1;
        end
        return {tr, sgn, 9'(sc), frac, 2'b00};
    endfunction

    function automatic logic [37:0] rand_operand();
        logic [7:0] sc;
        sc = 8'($urandom_range(0, 120)) - 8'd60;
        return {1'($urandom), sc, 27'($urandom), 2'b00};
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (check_ready)
                check_output("in_ready", {68'b0, in_ready}, {68'b0, !(exp_q.size() == 3 && !out_ready)});
            if (prev_stall)
                check_output("hold_stable", {truncated, result}, prev_word);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_out", 69'd1, 69'd0);
                end else begin
                    check_output("scoreboard", {truncated, result}, exp_q.pop_front());
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model_product(in1, in2));
            prev_stall = out_valid && !out_ready;
            prev_word  = {truncated, result};
        end
    end

    // Present one operand pair and return just after it is accepted.
    task automatic apply_stimulus(input logic [37:0] a, input logic [37:0] b);
        bit done;
        done     = 1'b0;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        if (!done) check_output("accept_timeout", 69'd0, 69'd1);
    endtask

    // One isolated product: check latency and the directed expected word.
    task automatic run_single(input string tag, input logic [37:0] a, input logic [37:0] b,
                              input logic [68:0] expected);
        int lat;
        apply_stimulus(a, b);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_output({tag, "_latency"}, 69'(lat), 69'd3);
        check_output(tag, {truncated, result}, expected);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk); #1;
        check_output("reset_out_valid", {68'b0, out_valid}, 69'd0);
        check_output("reset_result", {truncated, result}, 69'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("ready_after_reset", {68'b0, in_ready}, 69'd1);

        run_single("one_x_one", 38'h0, 38'h0, 69'h0);
        run_single("p15_x_m15", {1'b0, 8'd0, 27'h4000000, 2'b00}, {1'b1, 8'd0, 27'h4000000, 2'b00},
                   {1'b0, 1'b1, 9'd1, 56'h20000000000000, 2'b00});
        run_single("clamp_max", {1'b0, 8'd100, 27'd0, 2'b00}, {1'b0, 8'd100, 27'd0, 2'b00},
                   {1'b0, 1'b0, 9'd120, 56'd0, 2'b00});
        run_single("clamp_min", {1'b0, 8'h9C, 27'd0, 2'b00}, {1'b0, 8'h9C, 27'd0, 2'b00},
                   {1'b1, 1'b0, 9'h188, 56'd0, 2'b00});
        run_single("inf_x_zero", {1'b0, 8'd0, 27'd0, 2'b10}, {1'b0, 8'd0, 27'd0, 2'b01}, 69'h2);
        run_single("norm_x_zero", {1'b1, 8'd5, 27'h123, 2'b00}, {1'b0, 8'd0, 27'd0, 2'b01}, 69'h1);

        // Back-to-back operands against a 1,0,0,1 ready pattern.
        base = n_out;
        check_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) apply_stimulus(rand_operand(), rand_operand());
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 300 && n_out < base + 8; c++) begin
                    out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        check_ready = 1'b0;
        check_output("burst_count", 69'(n_out - base), 69'd8);
        check_output("burst_queue_empty", 69'(exp_q.size()), 69'd0);

        // Fill the pipe while stalled, then reset it.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(rand_operand(), rand_operand());
        in_valid = 1'b0;
        check_output("full_before_reset", {68'b0, out_valid}, 69'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        check_output("reset_mid_valid", {68'b0, out_valid}, 69'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_output("no_output_after_reset", 69'(seen), 69'd0);
        run_single("after_reset", 38'h0, 38'h0, 69'h0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
